// File: rtl/packet_generator_pkg.sv
// Shared types and constants for the packet generator: FSM state encoding and
// payload lane layout. The GAP state exists only when PKTGEN_GAP_EN is defined.
package packet_generator_pkg;

   localparam int LANE_W       = 64;
   localparam int IDX_W        = 32;
   localparam int BEAT_IDX_LSB = 0;
   localparam int PKT_IDX_LSB  = 32;

   // Encodings are pinned so the debug state output reads the same in both builds.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
`ifdef PKTGEN_GAP_EN
      ST_GAP  = 2'd2,
`endif
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/packet_generator_if.sv
// AXI-Stream style output bus of the packet generator.
// Valid/ready: a beat transfers when tvalid and tready are high at the same rising
// edge; once tvalid is high, tvalid/tdata/tlast hold until that transfer.
interface packet_generator_if #(
   parameter int DW = 128
);
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic          tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pktgen_payload.sv
// Beat payload former: {packet index, beat index} in one 64-bit lane,
// replicated across the full stream width.
module pktgen_payload
   import packet_generator_pkg::*;
#(
   parameter int DW    = 128,
   parameter int LEN_W = 16
) (
   input  logic [LEN_W-1:0] pkt_idx,
   input  logic [LEN_W-1:0] beat_idx,
   output logic [DW-1:0]    data
);

   logic [LANE_W-1:0] lane;

   always_comb begin
      lane = '0;
      lane[PKT_IDX_LSB +: IDX_W]  = IDX_W'(pkt_idx);
      lane[BEAT_IDX_LSB +: IDX_W] = IDX_W'(beat_idx);
   end

   assign data = {(DW / LANE_W){lane}};

endmodule

// File: rtl/packet_generator.sv
// Packet generator: emits pkt_count packets of pkt_len beats on a stream bus,
// with optional inter-packet idle gaps when PKTGEN_GAP_EN is defined.
module packet_generator
   import packet_generator_pkg::*;
#(
   parameter int DW    = 128,
   parameter int LEN_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  pkt_len,
   input  logic [LEN_W-1:0]  pkt_count,
`ifdef PKTGEN_GAP_EN
   input  logic [7:0]        gap_len,
`endif
   packet_generator_if.master axis_out,
   output logic              busy,
   output logic              done,
   output logic [63:0]       beats_sent,
   output logic [63:0]       packets_sent,
   output logic [1:0]        dbg_state
);

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic [LEN_W-1:0]  pkt_q, pkt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
`ifdef PKTGEN_GAP_EN
   logic [7:0]        gap_q, gap_d;
   logic [7:0]        gap_cnt_q, gap_cnt_d;
`endif
   logic [DW-1:0]     tdata_q, tdata_d;
   logic              valid_q, valid_d;
   logic              tlast_q, tlast_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [63:0]       beats_q, beats_d;
   logic [63:0]       packets_q, packets_d;
   logic              hs;
   logic              pkt_last;

   assign hs       = valid_q & axis_out.tready;
   assign pkt_last = (pkt_q == cnt_q - LEN_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         beat_q    <= '0;
         pkt_q     <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
`ifdef PKTGEN_GAP_EN
         gap_q     <= '0;
         gap_cnt_q <= '0;
`endif
         tdata_q   <= '0;
         valid_q   <= 1'b0;
         tlast_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         beats_q   <= '0;
         packets_q <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         pkt_q     <= pkt_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
`ifdef PKTGEN_GAP_EN
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
`endif
         tdata_q   <= tdata_d;
         valid_q   <= valid_d;
         tlast_q   <= tlast_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         beats_q   <= beats_d;
         packets_q <= packets_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = (pkt_count != '0) ? ST_SEND : ST_DONE;
         ST_SEND: begin
            if (hs && tlast_q) begin
               if (pkt_last) state_d = ST_DONE;
`ifdef PKTGEN_GAP_EN
               else if (gap_q != 8'd0) state_d = ST_GAP;
`endif
            end
         end
`ifdef PKTGEN_GAP_EN
         ST_GAP:  if (gap_cnt_q == 8'd1) state_d = ST_SEND;
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Indices, latched run parameters and next values of the registered outputs.
   always_comb begin
      beat_d    = beat_q;
      pkt_d     = pkt_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
`ifdef PKTGEN_GAP_EN
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
`endif
      if (state_q == ST_IDLE && start) begin
         len_d  = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
         cnt_d  = pkt_count;
         beat_d = '0;
         pkt_d  = '0;
`ifdef PKTGEN_GAP_EN
         gap_d  = gap_len;
`endif
      end else if (state_q == ST_SEND && hs) begin
         if (tlast_q) begin
            beat_d = '0;
            if (!pkt_last) pkt_d = pkt_q + LEN_W'(1);
`ifdef PKTGEN_GAP_EN
            gap_cnt_d = gap_q;
`endif
         end else begin
            beat_d = beat_q + LEN_W'(1);
         end
`ifdef PKTGEN_GAP_EN
      end else if (state_q == ST_GAP) begin
         gap_cnt_d = gap_cnt_q - 8'd1;
`endif
      end

      valid_d   = (state_d == ST_SEND);
      tlast_d   = valid_d && (beat_d == len_d - LEN_W'(1));
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
      beats_d   = beats_q + (hs ? 64'd1 : 64'd0);
      packets_d = packets_q + ((hs && tlast_q) ? 64'd1 : 64'd0);
   end

   pktgen_payload #(
      .DW    (DW),
      .LEN_W (LEN_W)
   ) u_payload (
      .pkt_idx  (pkt_d),
      .beat_idx (beat_d),
      .data     (tdata_d)
   );

   assign axis_out.tdata  = tdata_q;
   assign axis_out.tvalid = valid_q;
   assign axis_out.tlast  = tlast_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign beats_sent      = beats_q;
   assign packets_sent    = packets_q;
   assign dbg_state       = state_q;

endmodule

// File: doc/packet_generator.md
PACKET_GENERATOR -- requirements
Module: packet_generator

Interface
REQ-001 Parameter DW, default 128, SHALL set the stream data width in bits; legal values are multiples of 64 and at least 64.
REQ-002 Parameter LEN_W, default 16, SHALL set the width of the packet-length and packet-count inputs.
REQ-003 clk  input  1  sole clock; all logic SHALL be synchronous to its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a run, sampled only in IDLE.
REQ-006 pkt_len  input  LEN_W  beats per packet, latched on an accepted start.
REQ-007 pkt_count  input  LEN_W  packets per run, latched on an accepted start.
REQ-008 gap_len  input  8  idle cycles between packets, latched on an accepted start; present only with PKTGEN_GAP_EN.
REQ-009 axis_out_tdata  output  DW  generated beat payload.
REQ-010 axis_out_tvalid  output  1  beat valid.
REQ-011 axis_out_tlast  output  1  last beat of the current packet.
REQ-012 axis_out_tready  input  1  sink ready.
REQ-013 busy  output  1  high in every state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at the end of a run.
REQ-015 beats_sent  output  64  total accepted beats since reset.
REQ-016 packets_sent  output  64  total accepted tlast beats since reset.

Function
REQ-017 The FSM SHALL have states IDLE, SEND, GAP and DONE.
- IDLE->SEND: start=1 and pkt_count!=0.
- IDLE->DONE: start=1 and pkt_count==0.
- SEND->GAP: handshake on a tlast beat, more packets remain, latched gap!=0.
- SEND->SEND: handshake on a tlast beat, more packets remain, latched gap==0.
- SEND->DONE: handshake on the tlast beat of the final packet.
- GAP->SEND: gap counter expires.
- DONE->IDLE: unconditionally after one cycle.
REQ-018 All outputs SHALL be registered.
REQ-019 tvalid SHALL rise in the cycle after start is accepted (1-cycle latency).
REQ-020 A handshake SHALL occur when tvalid and tready are both high in the same cycle.
REQ-021 Once tvalid is asserted, tvalid, tdata and tlast SHALL hold stable until the handshake.
REQ-022 tvalid SHALL be low in IDLE, GAP and DONE.
REQ-023 With back-to-back packets and tready=1, the generator SHALL sustain one beat per cycle with no bubble between packets.
REQ-024 tdata[31:0] SHALL be the beat index within the packet, starting at 0.
REQ-025 tdata[63:32] SHALL be the packet index within the run, starting at 0.
REQ-026 tdata[63:0] SHALL be replicated across all upper 64-bit lanes.
REQ-027 tlast SHALL be high only on beat index pkt_len-1.
REQ-028 A latched pkt_len of 0 SHALL be treated as 1.
REQ-029 start SHALL be ignored while busy; the latched parameters SHALL not change mid-run.
REQ-030 done SHALL be high only in the DONE state, including for pkt_count==0 runs.
REQ-031 beats_sent SHALL increment on every handshake; packets_sent SHALL increment on every tlast handshake; both SHALL wrap modulo 2^64.
REQ-032 In GAP, exactly the latched gap_len idle cycles SHALL separate the last handshake of one packet from the next rise of tvalid.

Reset
REQ-033 While reset=1 the block SHALL enter IDLE on the next edge, with tvalid, tlast, busy and done at 0, tdata at 0 and both statistics counters at 0.
REQ-034 A reset mid-packet SHALL abandon the run immediately; no done pulse SHALL be emitted, and the next start SHALL begin at packet 0, beat 0.

Configuration
REQ-035 Macro PKTGEN_GAP_EN SHALL compile the gap feature in or out.
- Defined: the gap_len port and the GAP state exist.
- Undefined: gap_len is absent, the GAP state is removed, and packets are always back-to-back.

Structure
REQ-036 A shared package SHALL hold the FSM state enumeration, the lane width constant (64) and the index field offsets (0, 32).
REQ-037 One sub-module, pktgen_payload, SHALL form tdata from the packet and beat indices and DW; all other logic SHALL be flat.

Verification
REQ-038 pkt_len=4, pkt_count=2, gap_len=0, tready=1 -> 8 consecutive beats; tlast on beats 3 and 7; tdata[63:32]=0 then 1; done 1 cycle after the last beat; beats_sent=8, packets_sent=2.
REQ-039 pkt_len=3, pkt_count=1, tready toggling 1010... -> tdata and tvalid stable whenever tready=0; 3 beats accepted; tdata[31:0]=0,1,2.
REQ-040 pkt_count=0 -> no tvalid, busy high for 1 cycle, single done pulse.
REQ-041 PKTGEN_GAP_EN, pkt_len=2, pkt_count=3, gap_len=5, tready=1 -> exactly 5 idle cycles between packets; 6 beats total.
REQ-042 reset asserted on beat 2 of 4 -> tvalid low next cycle, no done pulse; a new start emits packet index 0, beat 0.
REQ-043 start pulsed during a run -> ignored; run length unchanged.
